// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the memory-dump sequencer and the UART
// transmitter. It absorbs the sequencer's bursty output so that flash reads
// can overlap with serial transmission. Both sides use a valid/ready handshake.
//
// Parameters:
//   DEPTH_LOG2  log2 of the FIFO depth; depth = 2**DEPTH_LOG2 (legal range 1..10)
//   DATA_W      byte width (8 for UART use)
//
// Ports:
//   clk        system clock (single clock domain)
//   nreset     asynchronous active-low reset; drops all stored bytes
//   flush      synchronous clear; takes priority over push and pop
//   in_valid   upstream byte valid
//   in_ready   FIFO can accept a byte (= !full, pointer-derived)
//   in_data    upstream byte
//   out_valid  a byte is available at the head
//   out_ready  downstream accepts the head byte
//   out_data   head-of-FIFO byte (0 when nothing is available)
//   level      number of stored bytes, 0..2**DEPTH_LOG2
//
// Build option:
//   UART_TX_FIFO_BYPASS_EN  when defined, an empty FIFO falls through: in_data
//                           appears on out_data in the same cycle, and the byte
//                           skips storage when out_ready is also high.
//                           When undefined, a pushed byte needs one clock
//                           before it can be seen at the output.

module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // The extra MSB on each pointer is the wrap bit. It distinguishes full
    // from empty when the low bits are equal.
    logic [DEPTH_LOG2:0]  wr_ptr;
    logic [DEPTH_LOG2:0]  rd_ptr;
    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DATA_W-1:0]    head;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // The modulo subtraction gives the right count across a pointer wrap.
    // The difference never exceeds DEPTH, so it fits in DEPTH_LOG2+1 bits.
    assign level    = wr_ptr - rd_ptr;
    assign in_ready = !full;
    assign head     = mem[rd_ptr[DEPTH_LOG2-1:0]];

`ifdef UART_TX_FIFO_BYPASS_EN
    logic bypass;

    // Direct hand-off: the FIFO is empty and both sides are ready, so the
    // byte never touches storage and neither pointer moves.
    assign bypass    = empty && in_valid && out_ready && !flush;
    assign out_valid = !flush && (!empty || in_valid);
    assign out_data  = !empty   ? head    :
                       in_valid ? in_data : '0;
    assign push      = in_valid && in_ready && !flush && !bypass;
    assign pop       = !empty && out_ready && !flush;
`else
    assign out_valid = !empty;
    // out_data reads 0 when empty so that the reset value is well defined
    // even though the storage array itself is not reset.
    assign out_data  = empty ? '0 : head;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately left without a reset. Its contents are only
    // visible through the pointers, and the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       nreset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] level;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    logic [7:0] exp_bytes [4];
    logic [7:0] q [$];
    logic [7:0] cur;
    logic       exp_push;
    logic       exp_pop;

    initial begin
        nreset    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset and idle
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_level",     level,     0);
        chk("rst_out_data",  out_data,  0);
        nreset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_out_valid", out_valid, 0);
            chk("idle_level",     level,     0);
            chk("idle_in_ready",  in_ready,  1);
        end

        // Ordered stream with out_ready low, then drain
        exp_bytes[0] = 8'h21;
        exp_bytes[1] = 8'hFE;
        exp_bytes[2] = 8'h00;
        exp_bytes[3] = 8'h55;
        push_byte(exp_bytes[0]);
        // The first byte must be visible right after its push edge.
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_data",  out_data,  8'h21);
        for (int i = 1; i < 4; i++) push_byte(exp_bytes[i]);
        chk("ord_level", level, 4);
        step();
        step();
        chk("ord_hold_data", out_data, 8'h21);
        chk("ord_hold_lvl",  level,    4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ord_valid", out_valid, 1);
            chk("ord_data",  out_data,  exp_bytes[i]);
            step();
        end
        chk("ord_empty_valid", out_valid, 0);
        chk("ord_empty_level", level,     0);
        out_ready = 1'b0;

        // Full boundary
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("full_level",    level,    16);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        step();
        step();
        chk("full_reject_lvl", level,    16);
        chk("full_head",       out_data, 8'h00);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("full_pop_level", level,    15);
        chk("full_pop_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("full_aa_level", level, 16);
        out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("full_drain", out_data, 8'(i));
            step();
        end
        chk("full_last_aa",    out_data,  8'hAA);
        step();
        chk("full_done_valid", out_valid, 0);
        chk("full_done_level", level,     0);

        // Wrap with push and pop held high together, checked against a queue model
        q.delete();
        for (int i = 0; i < 100; i++) begin
            cur      = 8'(i + 8'hF0);
            in_valid = 1'b1;
            in_data  = cur;
            chk("wrap_level", level, q.size());
            if (q.size() > 0) chk("wrap_data", out_data, q[0]);
            exp_push = (q.size() < 16);
            exp_pop  = (q.size() > 0);
            step();
            if (exp_pop)  void'(q.pop_front());
            if (exp_push) q.push_back(cur);
        end
        in_valid = 1'b0;
        chk("wrap_end_level", level, 1);
        chk("wrap_end_data",  out_data, 8'h53);
        step();
        chk("wrap_drained", out_valid, 0);
        out_ready = 1'b0;

        // Flush mid-stream at level 5, with a byte presented in the same cycle
        for (int i = 0; i < 5; i++) push_byte(8'(8'h30 + i));
        chk("fl_pre_level", level, 5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_level",    level,     0);
        chk("fl_valid",    out_valid, 0);
        chk("fl_in_ready", in_ready,  1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_77", out_valid, 0);
        end
        push_byte(8'h12);
        chk("fl_after_valid", out_valid, 1);
        chk("fl_after_data",  out_data,  8'h12);
        step();
        chk("fl_after_empty", out_valid, 0);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a transfer
        for (int i = 0; i < 3; i++) push_byte(8'(8'hC0 + i));
        chk("ar_pre_level", level, 3);
        #2;
        nreset = 1'b0;
        #1;
        chk("ar_level",    level,     0);
        chk("ar_valid",    out_valid, 0);
        chk("ar_data",     out_data,  0);
        chk("ar_in_ready", in_ready,  1);
        step();
        nreset = 1'b1;
        step();
        chk("ar_post_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
